// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding and widths for the pooling stage.
package pool_pkg;
  typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, POOL, WRITE, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADR_W = 7;
endpackage

// File: rtl/relu_max4.sv
// relu_max4: max of four signed bytes clamped at zero.
module relu_max4
  import pool_pkg::*;
(
  input  logic signed [BYTE_W-1:0] a,
  input  logic signed [BYTE_W-1:0] b,
  input  logic signed [BYTE_W-1:0] c,
  input  logic signed [BYTE_W-1:0] d,
  output logic        [BYTE_W-1:0] y
);
  logic signed [BYTE_W-1:0] ab, cd, m;
  always_comb begin
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    m = ab > cd ? ab : cd;
    y = m[BYTE_W-1] ? '0 : m;
  end
endmodule

// File: rtl/pool_unit.sv
// pool_unit: ReLU + 2x2 stride-2 max pooling over a packed byte feature map in word memory.
module pool_unit
  import pool_pkg::*;
#(
  parameter int FM_W = 16,
  parameter int FM_H = 16,
  parameter int BASE_IN = 0,
  parameter int BASE_OUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [ADR_W-1:0]  rdAdr,
  input  logic [WORD_W-1:0] rdData,
  output logic              we,
  output logic [ADR_W-1:0]  wrAdr,
  output logic [WORD_W-1:0] wrData
);
  localparam int WPR = FM_W / 4;
  localparam int PH = FM_H / 2;
  localparam int CW = WPR > 1 ? $clog2(WPR) : 1;
  localparam int PW = $clog2(PH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] p_q, p_d;
  logic [ADR_W-1:0] out_cnt_q, out_cnt_d, top_adr_q, top_adr_d, nxt_top;
  logic [ADR_W-1:0] rd_adr_q, rd_adr_d, wr_adr_q, wr_adr_d;
  logic [WORD_W-1:0] top_word_q, top_word_d, wr_data_q, wr_data_d;
  logic [2*BYTE_W-1:0] pk_q, pk_d;
  logic half_q, half_d, busy_q, busy_d, done_q, done_d, re_q, re_d, we_q, we_d;
  logic [BYTE_W-1:0] lo, hi;
  logic last_c, last_pair;
  relu_max4 u_lo (.a(top_word_q[7:0]), .b(top_word_q[15:8]), .c(rdData[7:0]), .d(rdData[15:8]), .y(lo));
  relu_max4 u_hi (.a(top_word_q[23:16]), .b(top_word_q[31:24]), .c(rdData[23:16]), .d(rdData[31:24]), .y(hi));
  assign last_c = c_q == CW'(WPR - 1);
  assign last_pair = last_c && p_q == PW'(PH - 1);
  // end of a row skips the bottom row of the pair just consumed
  assign nxt_top = last_c ? top_adr_q + ADR_W'(WPR + 1) : top_adr_q + 1'b1;
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    p_d = p_q;
    out_cnt_d = out_cnt_q;
    top_adr_d = top_adr_q;
    top_word_d = top_word_q;
    pk_d = pk_q;
    half_d = half_q;
    re_d = 1'b0;
    we_d = 1'b0;
    done_d = 1'b0;
    rd_adr_d = rd_adr_q;
    wr_adr_d = wr_adr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RD_TOP;
        re_d = 1'b1;
        rd_adr_d = ADR_W'(BASE_IN);
        top_adr_d = ADR_W'(BASE_IN);
        c_d = '0;
        p_d = '0;
        out_cnt_d = '0;
        pk_d = '0;
        half_d = 1'b0;
      end
      RD_TOP: begin
        state_d = RD_BOT;
        re_d = 1'b1;
        rd_adr_d = top_adr_q + ADR_W'(WPR);
      end
      RD_BOT: begin
        state_d = POOL;
        top_word_d = rdData;
      end
      POOL: begin
        pk_d = {hi, lo};
        half_d = !half_q;
        c_d = last_c ? '0 : c_q + 1'b1;
        p_d = p_q + PW'(last_c);
        top_adr_d = nxt_top;
        if (half_q) begin
          state_d = WRITE;
          we_d = 1'b1;
          wr_adr_d = ADR_W'(BASE_OUT) + out_cnt_q;
          wr_data_d = {hi, lo, pk_q};
        end else if (last_pair) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          state_d = RD_TOP;
          re_d = 1'b1;
          rd_adr_d = nxt_top;
        end
      end
      WRITE: begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (p_q == PW'(PH)) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          state_d = RD_TOP;
          re_d = 1'b1;
          rd_adr_d = top_adr_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      p_q <= '0;
      out_cnt_q <= '0;
      top_adr_q <= '0;
      top_word_q <= '0;
      pk_q <= '0;
      half_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      rd_adr_q <= '0;
      wr_adr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      p_q <= p_d;
      out_cnt_q <= out_cnt_d;
      top_adr_q <= top_adr_d;
      top_word_q <= top_word_d;
      pk_q <= pk_d;
      half_q <= half_d;
      busy_q <= busy_d;
      done_q <= done_d;
      re_q <= re_d;
      we_q <= we_d;
      rd_adr_q <= rd_adr_d;
      wr_adr_q <= wr_adr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign re = re_q;
  assign we = we_q;
  assign rdAdr = rd_adr_q;
  assign wrAdr = wr_adr_q;
  assign wrData = wr_data_q;
endmodule

// File: doc/pool_unit.md
# pool_unit

Downstream post-processing stage of the CNN convolution datapath. It reads the 8-bit convolution results from the output memory, where they are packed four per 32-bit word, and applies ReLU plus 2×2 stride-2 max pooling. It writes the pooled bytes back, packed four per word, into a separate output region of the same memory. A top-level controller drives it through a start/done handshake once the convolution pass has finished.

## Interface
Parameters:
- FM_W, 16: input feature-map width in bytes; must be a multiple of 8.
- FM_H, 16: input feature-map height in rows; must be even.
- BASE_IN, 0: word address of input row 0, word 0.
- BASE_OUT, 64: word address of pooled row 0, word 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch one pooling pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last write.
- re  out  1  memory read enable.
- rdAdr  out  7  memory read word address.
- rdData  in  32  read data, valid the cycle after re; byte k = bits [8k+7:8k] = column 4·word+k.
- we  out  1  memory write enable.
- wrAdr  out  7  memory write word address.
- wrData  out  32  packed pooled bytes, same byte order as rdData.

## Operation
- Bytes are signed two's complement. Pooled value = max(0, max of the 2×2 window), an unsigned byte in 0..127.
- Iteration order:
  - Row pair p runs 0..FM_H/2−1, outer loop.
  - Word column c runs 0..FM_W/4−1, inner loop.
  - Top address = BASE_IN + 2p·(FM_W/4) + c; bottom address = top + FM_W/4.
  - Addresses are produced by adders and counters; no multiplier.
- One word pair (top + bottom) gives two pooled bytes:
  - lo = window over bytes 0,1 of both rows.
  - hi = window over bytes 2,3 of both rows.
- Packer: 32-bit register plus 1-bit half flag.
  - First word pair fills bytes 0,1; second fills bytes 2,3.
  - Then the word is written at BASE_OUT + outCnt, and outCnt increments.
- FSM states:
  - IDLE: start → RD_TOP.
  - RD_TOP: re=1, rdAdr=top → RD_BOT.
  - RD_BOT: re=1, rdAdr=bottom; capture rdData as the top word → POOL.
  - POOL: capture the bottom word, compute, load the packer. Half flag was 1 → WRITE; otherwise last pair → DONE, else → RD_TOP.
  - WRITE: we=1, wrAdr=BASE_OUT+outCnt, wrData=packer → DONE if last pair, else RD_TOP.
  - DONE: done=1 → IDLE.
- Counters c, p, outCnt and the packer are cleared on entry to RD_TOP from IDLE.
- Because FM_W is a multiple of 8, the packer is always complete at the end of a row; no partial words are ever written.

## Timing
- Reset values: all outputs 0 (busy, done, re, we, rdAdr, wrAdr, wrData); FSM in IDLE; counters and packer cleared.
- Per word pair: 3 cycles (RD_TOP, RD_BOT, POOL), plus 1 WRITE cycle every second pair.
- Pass length = start sample + (FM_H/2)(FM_W/4)·3 + (FM_H/2)(FM_W/8) WRITE cycles + 1 DONE cycle.
  - Defaults: 96 + 16 + 1; done is high 113 cycles after the cycle start is sampled.
- re and we are never high in the same cycle. rdAdr and wrAdr hold their last value when the enables are low.
- start while busy is ignored. start in the DONE cycle is ignored. start in the cycle after DONE (IDLE) begins a new pass.
- rst mid-pass aborts on the next edge: back to IDLE, outputs 0, no further writes. Words already written stay in memory.
- Address wrap: BASE parameters must keep every address ≤127. No wrap is performed.

## Structure
- Package pool_pkg: state enum (IDLE, RD_TOP, RD_BOT, POOL, WRITE, DONE), BYTE_W=8, WORD_W=32, ADR_W=7.
- Sub-module relu_max4: combinational, four signed bytes → unsigned byte max(0, max). Instantiated twice (lo, hi).

## Test plan
- All input bytes 0x05, defaults → 16 writes of 0x05050505 to addresses 64..79; done pulse at cycle 113; no write outside 64..79.
- All input bytes 0x80 (−128) → every output word 0x00000000.
- All bytes 0x00 except row 3, column 5 = 0x7F → word 66 = 0x007F0000; all other output words 0.
- Input row 2k byte = 2k, row 2k+1 byte = −1 → pooled row k is all 2k. Checks lo/hi placement and row pairing.
- rst asserted while in WRITE at cycle 40 → next cycle: IDLE, we=0, busy=0. A new start then reproduces the full first-scenario result.
- start held high for the whole pass → exactly one pass is run, then a second pass starts on the cycle after DONE.
